led_fx_driver: RTL and testbench
================================

LED_FX_DRIVER -- requirements
Module: led_fx_driver

Interface
REQ-001 SHALL have parameter LED_W, default 9, number of LED lanes driven.
REQ-002 SHALL have parameter PRESCALE_W, default 16, width of the tick prescaler PERIOD register.
REQ-003 SHALL have port clk, input, 1, sole clock; all state is rising-edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port led_req, input, LED_W, requested LED pattern from the green-LED PIO out_port.
REQ-006 SHALL have port address, input, 2, config register select.
REQ-007 SHALL have port chipselect, input, 1, config slave select.
REQ-008 SHALL have port write_n, input, 1, active-low write strobe.
REQ-009 SHALL have port writedata, input, 32, config write data.
REQ-010 SHALL have port readdata, output, 32, config read data, zero-extended.
REQ-011 SHALL have port led_out, output, LED_W, registered drive to the physical LEDs.

Function
REQ-012 SHALL decode registers: 0 CTRL[1:0] mode (0 PASS, 1 BLINK, 2 BREATHE, 3 treated as PASS); 1 DUTY[7:0]; 2 PERIOD[PRESCALE_W-1:0]; 3 STATUS, read-only, equal to led_out.
REQ-013 SHALL accept a write when chipselect=1, write_n=0; the new value takes effect on the next clock edge; writes to address 3 are ignored.
REQ-014 SHALL drive readdata combinationally from address with zero wait states: the selected register, zero-extended, when chipselect=1; 0 otherwise.
REQ-015 SHALL generate a one-cycle tick when the prescale counter equals PERIOD, clearing the counter that cycle; otherwise the counter increments; PERIOD=0 yields a tick every cycle.
REQ-016 SHALL run a free-running 8-bit PWM counter; pwm_on(d) = (pwm_cnt < d) or (d = 255).
REQ-017 PASS: led_out <= led_req & {LED_W{pwm_on(DUTY)}}, one cycle of latency.
REQ-018 BLINK: a phase bit toggles on each tick; led_out <= phase ? (led_req & pwm_on(DUTY)) : 0.
REQ-019 BREATHE: FSM states UP and DOWN with an 8-bit level; UP: level+1 on tick, moves to DOWN on the tick that reaches 255; DOWN: level-1 on tick, moves to UP on the tick that reaches 0; level never wraps; led_out <= led_req & pwm_on(level).
REQ-020 SHALL, on any CTRL write (including rewriting the same value), clear the prescale counter, set phase=1, level=0 and state=UP in the same edge.
REQ-021 SHALL take the CTRL write when a CTRL write and a tick coincide (the write wins); the tick is discarded.
REQ-022 SHALL apply a PERIOD write below the current counter value by wrapping the counter via overflow to 0 before the next tick; no tick is lost permanently.

Reset
REQ-023 SHALL, on reset_n low, asynchronously set led_out=0, CTRL=0, DUTY=255, PERIOD=all ones, counters=0, phase=1, level=0, state=UP.
REQ-024 SHALL resume from reset values on the first edge after reset_n deasserts; a reset mid-BREATHE loses the ramp position.

Configuration
REQ-025 SHALL compile the PWM path only when LED_FX_PWM_EN is defined; with the macro, REQ-016 to REQ-019 apply as written.
REQ-026 SHALL, without LED_FX_PWM_EN, treat pwm_on() as constant 1, read DUTY as 0, ignore DUTY writes, and make BREATHE behave as BLINK with phase = level[7].

Structure
REQ-027 SHALL place the mode encodings, the register address constants and the reset values in shared package led_fx_pkg.
REQ-028 SHALL implement the prescaler (REQ-015, REQ-020, REQ-022) as sub-module led_fx_tick, with a synchronous clear input and a tick output.

Verification
REQ-029 Reset, then led_req=0x1FF in PASS with DUTY=255 -> led_out=0x1FF one cycle later; STATUS reads 0x1FF.
REQ-030 PASS, DUTY=64, led_req=0x001 -> led_out[0] high for exactly 64 of every 256 cycles.
REQ-031 BLINK, PERIOD=3, led_req=0x0AA, DUTY=255 -> led_out alternates 0x0AA and 0x000 every 4 cycles, starting with 0x0AA.
REQ-032 BREATHE, PERIOD=0 -> level climbs 0..255 in 255 ticks, then descends to 0, with no wrap at either end.
REQ-033 CTRL write in the same cycle as a tick -> counter=0, phase=1 next cycle, and no toggle.
REQ-034 Build without LED_FX_PWM_EN -> DUTY reads 0; PASS output equals led_req regardless of DUTY writes.

Source files
------------

// File: rtl/led_fx_pkg.sv
// Shared definitions for the LED effects driver: mode encodings, config
// register addresses, reset values and the PWM compare helper.
package led_fx_pkg;

   typedef enum logic [1:0] {
      MODE_PASS     = 2'd0,
      MODE_BLINK    = 2'd1,
      MODE_BREATHE  = 2'd2,
      MODE_PASS_ALT = 2'd3   // unused encoding, behaves as PASS
   } fx_mode_e;

   typedef enum logic {
      BR_UP   = 1'b0,
      BR_DOWN = 1'b1
   } br_state_e;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_DUTY   = 2'd1;
   localparam logic [1:0] ADDR_PERIOD = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam fx_mode_e   RST_CTRL  = MODE_PASS;
   localparam logic [7:0] RST_DUTY  = 8'hFF;
   localparam logic [7:0] RST_LEVEL = 8'h00;
   localparam logic       RST_PHASE = 1'b1;

   // Duty 255 means fully on, so the 8-bit counter never leaves a gap.
   function automatic logic pwm_on(input logic [7:0] cnt, input logic [7:0] d);
      return (cnt < d) || (d == 8'hFF);
   endfunction

endpackage

// File: rtl/led_fx_tick.sv
// Tick prescaler: counts up to PERIOD and emits a one-cycle tick when the
// counter equals PERIOD. A PERIOD lowered below the running count is
// reached again after the counter overflows to 0. clr restarts the count
// and suppresses any tick in the same cycle.
module led_fx_tick #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] period,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt;
   logic                  hit;

   assign hit  = (cnt == period);
   assign tick = hit && !clr;

   // Prescale counter: clear on config restart or on reaching PERIOD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (clr || hit)
         cnt <= '0;
      else
         cnt <= cnt + PRESCALE_W'(1);
   end

endmodule

// File: rtl/led_fx_driver.sv
// LED effects driver: PASS / BLINK / BREATHE on a registered LED output with
// a small memory-mapped config slave.
// Build option: define LED_FX_PWM_EN to include the PWM dimming path.
// Without it, outputs are never dimmed, DUTY reads 0 and BREATHE blinks
// with the top level bit as the phase.
module led_fx_driver
   import led_fx_pkg::*;
#(
   parameter int LED_W      = 9,
   parameter int PRESCALE_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [LED_W-1:0] led_req,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [LED_W-1:0] led_out
);

   fx_mode_e              ctrl_q;
   logic [PRESCALE_W-1:0] period_q;
   logic                  wr_en;
   logic                  ctrl_wr;
   logic                  tick;
   logic                  phase_q;
   logic [7:0]            level_q, level_d;
   br_state_e             state_q, state_d;
   logic                  on_duty;
   logic                  br_gate;
   logic [LED_W-1:0]      led_d;
   logic                  unused_wdata;

   assign wr_en        = chipselect && !write_n;
   assign ctrl_wr      = wr_en && (address == ADDR_CTRL);
   assign unused_wdata = ^writedata;

`ifdef LED_FX_PWM_EN
   logic [7:0] duty_q;
   logic [7:0] pwm_cnt;

   // Free-running PWM counter shared by all lanes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pwm_cnt <= 8'h00;
      else          pwm_cnt <= pwm_cnt + 8'h01;
   end

   // DUTY register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                duty_q <= RST_DUTY;
      else if (wr_en && (address == ADDR_DUTY))    duty_q <= writedata[7:0];
   end

   assign on_duty = pwm_on(pwm_cnt, duty_q);
   assign br_gate = pwm_on(pwm_cnt, level_q);
`else
   assign on_duty = 1'b1;
   assign br_gate = level_q[7];
`endif

   // CTRL and PERIOD registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q   <= RST_CTRL;
         period_q <= '1;
      end else if (wr_en) begin
         if (address == ADDR_CTRL)   ctrl_q   <= fx_mode_e'(writedata[1:0]);
         if (address == ADDR_PERIOD) period_q <= writedata[PRESCALE_W-1:0];
      end
   end

   led_fx_tick #(.PRESCALE_W(PRESCALE_W)) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (ctrl_wr),
      .period  (period_q),
      .tick    (tick)
   );

   // Breathe ramp next-state: saturating up/down walk of level, one step per tick.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      if (tick) begin
         unique case (state_q)
            BR_UP: begin
               if (level_q != 8'hFF) level_d = level_q + 8'h01;
               if (level_q >= 8'hFE) state_d = BR_DOWN;
            end
            BR_DOWN: begin
               if (level_q != 8'h00) level_d = level_q - 8'h01;
               if (level_q <= 8'h01) state_d = BR_UP;
            end
            default: state_d = BR_UP;
         endcase
      end
   end

   // Effect state: any CTRL write restarts ramp and blink phase; ticks advance them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BR_UP;
         level_q <= RST_LEVEL;
         phase_q <= RST_PHASE;
      end else if (ctrl_wr) begin
         state_q <= BR_UP;
         level_q <= RST_LEVEL;
         phase_q <= RST_PHASE;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         if (tick) phase_q <= ~phase_q;
      end
   end

   // Output pattern for the selected effect.
   always_comb begin
      led_d = led_req & {LED_W{on_duty}};
      unique case (ctrl_q)
         MODE_BLINK:   led_d = phase_q ? (led_req & {LED_W{on_duty}}) : '0;
         MODE_BREATHE: led_d = led_req & {LED_W{br_gate}};
         default:      led_d = led_req & {LED_W{on_duty}};
      endcase
   end

   // Registered LED drive.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) led_out <= '0;
      else          led_out <= led_d;
   end

   // Zero-wait-state read mux.
   always_comb begin
      readdata = 32'h0;
      if (chipselect) begin
         unique case (address)
            ADDR_CTRL:   readdata = 32'(ctrl_q);
`ifdef LED_FX_PWM_EN
            ADDR_DUTY:   readdata = 32'(duty_q);
`else
            ADDR_DUTY:   readdata = 32'h0;
`endif
            ADDR_PERIOD: readdata = 32'(period_q);
            default:     readdata = 32'(led_out);
         endcase
      end
   end

endmodule

// File: tb/tb_led_fx_driver.sv
// Scoreboard bench for led_fx_driver. Expected LED patterns come from a
// model expressed in ticks-since-restart and cycles-since-reset.
module tb_led_fx_driver;

   localparam int LED_W = 9;
   localparam int PW    = 16;
`ifdef LED_FX_PWM_EN
   localparam bit PWM = 1'b1;
`else
   localparam bit PWM = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [LED_W-1:0] led_req = '0;
   logic [1:0]       address = '0;
   logic             chipselect = 1'b0;
   logic             write_n = 1'b1;
   logic [31:0]      writedata = '0;
   logic [31:0]      readdata;
   logic [LED_W-1:0] led_out;

   led_fx_driver #(.LED_W(LED_W), .PRESCALE_W(PW)) dut (
      .clk(clk), .reset_n(reset_n), .led_req(led_req), .address(address),
      .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
      .readdata(readdata), .led_out(led_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [LED_W-1:0] exp_q[$];

   // reference model state
   int unsigned m_cyc;     // edges since reset release
   int unsigned m_nticks;  // ticks since last CTRL write
   logic [PW-1:0] m_cnt, m_period;
   int m_mode, m_duty;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic bit on(input int d);
      if (!PWM) return 1'b1;
      return ((m_cyc % 256) < d) || (d == 255);
   endfunction

   function automatic int tri_level();
      int k;
      k = int'(m_nticks % 510);
      return (k <= 255) ? k : 510 - k;
   endfunction

   function automatic void model_reset();
      m_cyc = 0; m_nticks = 0; m_cnt = '0; m_period = '1; m_mode = 0; m_duty = 255;
   endfunction

   // One clock: drive inputs, predict led_out after the edge, advance model.
   task automatic cycle(input logic [LED_W-1:0] req, input bit wr,
                        input logic [1:0] a, input logic [31:0] d);
      bit ctrl_wr, tick, gate;
      logic [LED_W-1:0] e;
      led_req = req; chipselect = wr; write_n = !wr; address = a; writedata = d;
      ctrl_wr = wr && (a == 2'd0);
      tick = (m_cnt == m_period) && !ctrl_wr;
      case (m_mode)
         1: gate = (m_nticks % 2 == 0) && on(m_duty);
         2: gate = PWM ? on(tri_level()) : (tri_level() >= 128);
         default: gate = on(m_duty);
      endcase
      e = gate ? req : '0;
      exp_q.push_back(e);
      m_cyc++;
      if (ctrl_wr) begin m_cnt = '0; m_nticks = 0; m_mode = int'(d[1:0]); end
      else if (tick) begin m_cnt = '0; m_nticks++; end
      else m_cnt = m_cnt + 1'b1;
      if (wr && a == 2'd1 && PWM) m_duty = int'(d[7:0]);
      if (wr && a == 2'd2) m_period = d[PW-1:0];
      @(posedge clk); #1;
   endtask

   task automatic idle(input logic [LED_W-1:0] req, input int n);
      for (int i = 0; i < n; i++) cycle(req, 1'b0, 2'd0, 32'h0);
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      chipselect = 1'b1; write_n = 1'b1; address = a; #1;
      chk(name, readdata, exp);
   endtask

   // Monitor: compare every registered output against the oldest prediction.
   always @(posedge clk) begin
      logic [LED_W-1:0] e;
      #3;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("led_out", 32'(led_out), 32'(e));
      end
   end

   initial begin
      int hi;
      logic [LED_W-1:0] pat;
      model_reset();
      #12;
      chk("rst_led", 32'(led_out), 32'h0);
      rd(2'd0, 32'h0, "rst_ctrl");
      rd(2'd1, PWM ? 32'hFF : 32'h0, "rst_duty");
      rd(2'd2, 32'hFFFF, "rst_period");
      rd(2'd3, 32'h0, "rst_status");
      chipselect = 1'b0; address = 2'd2; #1;
      chk("rd_nocs", readdata, 32'h0);
      @(negedge clk); reset_n = 1'b1;

      // PASS, full duty
      cycle(9'h1FF, 1'b1, 2'd0, 32'h0);
      idle(9'h1FF, 3);
      rd(2'd3, 32'h1FF, "status_1ff");

      // PASS, DUTY=64: 128 of 512 consecutive cycles lit
      cycle(9'h001, 1'b1, 2'd1, 32'd64);
      rd(2'd1, PWM ? 32'd64 : 32'h0, "duty_rd");
      cycle(9'h001, 1'b1, 2'd0, 32'h0);
      hi = 0;
      for (int i = 0; i < 512; i++) begin
         cycle(9'h001, 1'b0, 2'd0, 32'h0);
         if (led_out[0]) hi++;
      end
      chk("pwm_count", 32'(hi), PWM ? 32'd128 : 32'd512);

      // BLINK, PERIOD=3: 4 lit, 4 dark, starting lit
      cycle(9'h0AA, 1'b1, 2'd1, 32'd255);
      cycle(9'h0AA, 1'b1, 2'd2, 32'd3);
      rd(2'd2, 32'd3, "period_rd");
      cycle(9'h0AA, 1'b1, 2'd0, 32'd1);
      for (int i = 0; i < 16; i++) begin
         cycle(9'h0AA, 1'b0, 2'd0, 32'h0);
         pat = ((i / 4) % 2 == 0) ? 9'h0AA : 9'h000;
         chk("blink_pat", 32'(led_out), 32'(pat));
      end

      // CTRL write on a tick (PERIOD=0): phase restarts at 1, no toggle
      cycle(9'h0AA, 1'b1, 2'd2, 32'd0);
      cycle(9'h0AA, 1'b1, 2'd0, 32'd1);
      cycle(9'h0AA, 1'b0, 2'd0, 32'h0);
      chk("wr_vs_tick_lit", 32'(led_out), 32'h0AA);
      cycle(9'h0AA, 1'b0, 2'd0, 32'h0);
      chk("wr_vs_tick_dark", 32'(led_out), 32'h0);
      rd(2'd0, 32'd1, "ctrl_rd");

      // randomized segments
      for (int s = 0; s < 12; s++) begin
         int r;
         r = int'($urandom_range(0, 3));
         cycle(LED_W'($urandom), 1'b1, 2'd1,
               (r == 0) ? 32'd0 : (r == 1) ? 32'd255 : 32'($urandom_range(0, 255)));
         cycle(LED_W'($urandom), 1'b1, 2'd2, 32'($urandom_range(0, 4)));
         cycle(LED_W'($urandom), 1'b1, 2'd0, 32'($urandom_range(0, 3)));
         for (int i = 0; i < int'($urandom_range(40, 120)); i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 5)       cycle(LED_W'($urandom), 1'b1, 2'd1, 32'($urandom_range(0, 255)));
            else if (r < 8)  cycle(LED_W'($urandom), 1'b1, 2'd0, 32'($urandom_range(0, 3)));
            else if (r < 10) cycle(LED_W'($urandom), 1'b1, 2'd3, 32'h3);
            else             cycle(LED_W'($urandom), 1'b0, 2'd0, 32'h0);
         end
      end

      // BREATHE, PERIOD=0: full climb and descent
      cycle(9'h1FF, 1'b1, 2'd2, 32'd0);
      cycle(9'h1FF, 1'b1, 2'd0, 32'd2);
      idle(9'h1FF, 1100);

      // reset mid-ramp
      cycle(9'h1FF, 1'b1, 2'd0, 32'd2);
      idle(9'h1FF, 300);
      #5;
      reset_n = 1'b0; #1;
      chk("midrst_led", 32'(led_out), 32'h0);
      rd(2'd0, 32'h0, "midrst_ctrl");
      rd(2'd2, 32'hFFFF, "midrst_period");
      model_reset();
      chipselect = 1'b0; write_n = 1'b1;
      @(negedge clk); reset_n = 1'b1;
      cycle(9'h1FF, 1'b1, 2'd2, 32'd0);
      cycle(9'h1FF, 1'b1, 2'd0, 32'd2);
      idle(9'h1FF, 300);

      idle(9'h0, 2);
      #5;
      chk("sb_drain", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
